// File: rtl/uart_rx_buffer.sv
// UART 8N1 receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_buffer #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx,
    output logic [7:0]                 data,
    output logic                       valid,
    input  logic                       ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       frame_err,
    output logic                       overflow
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int BW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } state_t;
    localparam state_t S_AFTER_DATA = S_PARITY;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } state_t;
    localparam state_t S_AFTER_DATA = S_STOP;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [1:0]      r_sync;
    logic            r_rxs_d;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_rxs;
    logic            w_half;
    logic            w_full_tick;
    logic            w_push;
    logic            w_bad;
    logic            w_par_err;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic            r_valid;
    logic            r_frame_err;
    logic            r_overflow;
    logic            w_pop;
    logic            w_fifo_full;
    logic            w_wr;

    assign w_rxs       = r_sync[1];
    assign w_half      = (r_baud == BW'(HALF - 1));
    assign w_full_tick = (r_baud == BW'(DIV - 1));

    // Two-flop synchronizer plus one delayed copy for start-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_rxs_d <= r_sync[1];
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and stop-bit verdict
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rxs_d && !w_rxs) begin
                    w_next = S_START;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_half) begin
                    w_next = w_rxs ? S_IDLE : S_DATA;
                end else begin
                    w_next = S_START;
                end
            end
            S_DATA: begin
                if (w_full_tick && (r_bit == 3'd7)) begin
                    w_next = S_AFTER_DATA;
                end else begin
                    w_next = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full_tick) begin
                    w_next = S_STOP;
                end else begin
                    w_next = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_full_tick) begin
                    w_next = S_IDLE;
                    if (w_rxs && !w_par_err) begin
                        w_push = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end else begin
                    w_next = S_STOP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Baud counter restarts on every state entry and on every data-bit sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud <= '0;
        end else if ((r_state == S_IDLE) || (w_next != r_state) ||
                     ((r_state == S_DATA) && w_full_tick)) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + BW'(1);
        end
    end

    // Data shift register, LSB arrives first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_bit   <= 3'd0;
        end else if ((r_state == S_DATA) && w_full_tick) begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= {w_rxs, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    // Even parity: data bits plus parity bit must hold an even number of ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_par_err <= 1'b0;
        end else if ((r_state == S_PARITY) && w_full_tick) begin
            r_par_err <= w_rxs ^ (^r_shift);
        end
    end
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    assign w_pop       = r_valid && ready;
    assign w_fifo_full = (r_count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign w_wr        = w_push && (!w_fifo_full || w_pop);

    // Occupancy after this cycle's push and pop
    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_next;
            r_valid     <= (w_count_next != CW'(0));
            r_frame_err <= w_bad;
            r_overflow  <= r_overflow | (w_push && !w_wr);
        end
    end

    assign data      = r_mem[r_rd_ptr];
    assign valid     = r_valid;
    assign count     = r_count;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer at a reduced bit period (DIV = 32).
// Define UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_rx_buffer;

    localparam int CLK_HZ = 3200;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 16;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int HALF   = DIV / 2;
    localparam int CW     = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
    localparam int PUSH_EDGE = 3 + HALF + 10 * DIV;
`else
    localparam int PUSH_EDGE = 3 + HALF + 9 * DIV;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic [CW-1:0] count;
    logic          frame_err;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;

    uart_rx_buffer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .count     (count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            fe_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_byte(8'hA5, 1'b1, 1'b0);
        check_eq("a5_valid", 32'(valid), 32'd1);
        check_eq("a5_data", 32'(data), 32'hA5);
        check_eq("a5_count", 32'(count), 32'd1);
        check_eq("a5_ferr", 32'(fe_cnt), 32'd0);
        pop_one();
        check_eq("a5_pop_count", 32'(count), 32'd0);
        check_eq("a5_pop_valid", 32'(valid), 32'd0);

        @(negedge clk);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        check_eq("empty_pop_count", 32'(count), 32'd0);

        send_byte(8'h3C, 1'b0, 1'b0);
        check_eq("badstop_ferr", 32'(fe_cnt), 32'd1);
        check_eq("badstop_count", 32'(count), 32'd0);
        send_byte(8'h55, 1'b1, 1'b0);
        check_eq("after_bad_data", 32'(data), 32'h55);
        check_eq("after_bad_count", 32'(count), 32'd1);
        check_eq("after_bad_ferr", 32'(fe_cnt), 32'd1);
        pop_one();

        @(negedge clk);
        rx = 1'b0;
        repeat (HALF - 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_eq("glitch_count", 32'(count), 32'd0);
        check_eq("glitch_ferr", 32'(fe_cnt), 32'd1);
        send_byte(8'h5A, 1'b1, 1'b0);
        check_eq("post_glitch_data", 32'(data), 32'h5A);
        check_eq("post_glitch_count", 32'(count), 32'd1);
        pop_one();

        for (int i = 1; i <= 17; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        check_eq("fill17_count", 32'(count), 32'd16);
        check_eq("fill17_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            check_eq("fill17_pop", 32'(data), 32'(i));
            pop_one();
        end
        check_eq("drain_count", 32'(count), 32'd0);
        check_eq("drain_valid", 32'(valid), 32'd0);
        check_eq("ovf_sticky", 32'(overflow), 32'd1);

        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                repeat (200) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check_eq("midrst_ovf", 32'(overflow), 32'd0);
                reset = 1'b0;
            end
        join
        repeat (DIV) @(negedge clk);
        check_eq("midrst_count", 32'(count), 32'd0);
        check_eq("midrst_ferr", 32'(fe_cnt), 32'd1);

        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i), 1'b1, 1'b0);
        end
        check_eq("full16_count", 32'(count), 32'd16);
        check_eq("full16_ovf", 32'(overflow), 32'd0);
        fork
            send_byte(8'h7E, 1'b1, 1'b0);
            begin
                @(negedge rx);
                repeat (PUSH_EDGE - 1) @(posedge clk);
                @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        check_eq("pushpop_count", 32'(count), 32'd16);
        check_eq("pushpop_ovf", 32'(overflow), 32'd0);
        check_eq("pushpop_head", 32'(data), 32'h02);
        for (int i = 0; i < 15; i++) begin
            check_eq("pushpop_drain", 32'(data), 32'(i + 2));
            pop_one();
        end
        check_eq("pushpop_7e", 32'(data), 32'h7E);
        check_eq("pushpop_last_count", 32'(count), 32'd1);
        pop_one();

`ifdef UART_RX_PARITY_EN
        send_byte(8'h03, 1'b1, 1'b1);
        check_eq("par_bad_ferr", 32'(fe_cnt), 32'd2);
        check_eq("par_bad_count", 32'(count), 32'd0);
        send_byte(8'h03, 1'b1, 1'b0);
        check_eq("par_good_data", 32'(data), 32'h03);
        check_eq("par_good_count", 32'(count), 32'd1);
        check_eq("par_good_ferr", 32'(fe_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
